// File: rtl/mra_req_arbiter_pkg.sv
// Shared types and helpers for the MRA request arbiter: width helpers and the
// round-robin pick used by the grant logic.
package mra_arb_pkg;

  localparam int MAX_REQ  = 32;
  localparam int MAX_ID_W = 5;

  typedef struct packed {
    logic                found;
    logic [MAX_ID_W-1:0] id;
  } rr_pick_t;

  function automatic int id_w(input int numReq);
    return (numReq > 1) ? $clog2(numReq) : 1;
  endfunction

  function automatic int cnt_w(input int maxOut);
    return $clog2(maxOut + 1);
  endfunction

  // Scan last_gnt+1, +2, ... (mod num_req) and return the first valid requester.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                       input int numReq,
                                       input int lastGnt);
    rr_pick_t res;
    int       idx;
    res = '0;
    idx = 0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      if (k <= numReq) begin
        idx = (lastGnt + k) % numReq;
        if (!res.found && req[idx[MAX_ID_W-1:0]]) begin
          res.found = 1'b1;
          res.id    = idx[MAX_ID_W-1:0];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mra_req_arbiter_id_fifo.sv
// Synchronous FIFO holding the requester id of every issued MRA request so that
// in-order responses can be steered back to their issuer.
module mra_id_fifo
  import mra_arb_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 2,
  localparam int CNT_W = cnt_w(DEPTH),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign o_full      = (r_count == CNT_W'(DEPTH));
  assign o_empty     = (r_count == '0);
  assign o_count     = r_count;
  assign o_head_data = r_mem[r_rd_ptr];
  assign w_do_pop    = i_pop && !o_empty;
  assign w_do_push   = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Simultaneous push and pop advance both pointers and leave the count alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mra_req_arbiter.sv
// Round-robin arbiter sharing one MRA request port among NUM_REQ engines, with a
// one-entry output stage, an outstanding-request cap and in-order response steering.
module mra_req_arbiter
  import mra_arb_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int ADDR_WIDTH      = 64,
  parameter int MAX_OUTSTANDING = 8,
  localparam int ID_W  = id_w(NUM_REQ),
  localparam int CNT_W = cnt_w(MAX_OUTSTANDING)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr,
  input  logic [NUM_REQ-1:0]            i_req_rw,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic [ADDR_WIDTH-1:0]         o_mra_req_addr,
  output logic                          o_mra_rw,
  output logic                          o_mra_req_valid,
  input  logic                          i_mra_ready,
  input  logic                          i_mra_resp_valid,
  output logic [NUM_REQ-1:0]            o_resp_valid,
  output logic [CNT_W-1:0]              o_inflight_cnt,
  output logic                          o_resp_err
);

  logic [MAX_REQ-1:0]    w_req_ext;
  rr_pick_t              w_pick;
  logic [ID_W-1:0]       w_gnt_id;
  logic                  w_can_grant;
  logic                  w_grant;
  logic                  w_accept;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic [CNT_W-1:0]      w_fifo_count;
  logic [ID_W-1:0]       w_head_id;

  logic                  r_valid;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_rw;
  logic [ID_W-1:0]       r_id;
  logic [ID_W-1:0]       r_last_gnt;
  logic                  r_resp_err;

  always_comb begin
    w_req_ext                = '0;
    w_req_ext[NUM_REQ-1:0]   = i_req_valid;
  end

  assign w_pick   = rr_pick(w_req_ext, NUM_REQ, int'(r_last_gnt));
  assign w_gnt_id = ID_W'(w_pick.id);

  // In-flight count is stage occupancy plus ids waiting for a response, so a
  // pop this cycle only frees a slot from the next cycle onwards.
  assign o_inflight_cnt = w_fifo_count + CNT_W'(r_valid);
  assign w_can_grant    = (o_inflight_cnt < CNT_W'(MAX_OUTSTANDING)) && (!r_valid || i_mra_ready);
  assign w_grant        = !rst && w_can_grant && w_pick.found;
  assign o_req_ready    = w_grant ? (NUM_REQ'(1) << w_gnt_id) : '0;

  assign w_accept     = r_valid && i_mra_ready;
  assign w_push       = w_accept && !w_fifo_full;
  assign w_pop        = !rst && i_mra_resp_valid && !w_fifo_empty;
  assign o_resp_valid = w_pop ? (NUM_REQ'(1) << w_head_id) : '0;

  assign o_mra_req_addr  = r_addr;
  assign o_mra_rw        = r_rw;
  assign o_mra_req_valid = r_valid;
  assign o_resp_err      = r_resp_err;

  // A reload on the accept cycle keeps the stage full for back-to-back issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_addr     <= '0;
      r_rw       <= 1'b0;
      r_id       <= '0;
      r_last_gnt <= ID_W'(NUM_REQ - 1);
    end else if (w_grant) begin
      r_valid    <= 1'b1;
      r_addr     <= i_req_addr[w_gnt_id*ADDR_WIDTH +: ADDR_WIDTH];
      r_rw       <= i_req_rw[w_gnt_id];
      r_id       <= w_gnt_id;
      r_last_gnt <= w_gnt_id;
    end else if (w_accept) begin
      r_valid    <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_resp_err <= 1'b0;
    end else if (i_mra_resp_valid && w_fifo_empty) begin
      r_resp_err <= 1'b1;
    end
  end

  mra_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (ID_W)
  ) u_id_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_data (r_id),
    .i_pop       (w_pop),
    .o_head_data (w_head_id),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_count     (w_fifo_count)
  );

endmodule
